input_pixel_pingpong_buf: RTL and testbench
===========================================

Name: input_pixel_pingpong_buf

Overview:
Parametrised, double-banked successor to the single-bank input pixel buffer. The AHB-side pixel core writes DATA_W/8 byte lanes per beat into the fill bank. The rotate datapath reads NUM_CH independent byte channels from the other bank. The banks swap on handshake, so fill and read overlap without write-to-read forwarding.

Parameters:
DATA_W, 32, write beat width in bits; BPW = DATA_W/8 byte lanes.
DEPTH, 192, bytes per bank.
ADDR_W, 8, byte address width; must satisfy 2^ADDR_W >= DEPTH.
NUM_CH, 3, read channels (B,G,R for default).
PAD_VAL, 8'h00, byte returned for padded or out-of-range reads.

Ports:
I_IBUF_HCLK  in  1  clock
I_IBUF_HRESET_N  in  1  reset, asynchronous, active-low
I_IBUF_WVALID  in  1  write beat valid
O_IBUF_WREADY  out  1  fill bank can accept a beat
I_IBUF_WDATA  in  DATA_W  lane k = bits [8k+7:8k]
I_IBUF_WSTRB  in  BPW  per-lane write enable
I_IBUF_WADDR  in  BPW*ADDR_W  per-lane byte address
I_IBUF_FILL_LEN  in  ADDR_W+1  bytes that complete a bank; 0 means DEPTH
I_IBUF_RVALID  in  1  read request
I_IBUF_RADDR  in  NUM_CH*ADDR_W  per-channel read address
I_IBUF_RPAD  in  NUM_CH  per-channel pad force
O_IBUF_RDATA  out  NUM_CH*8  registered read bytes
O_IBUF_RDATA_VALID  out  1  RDATA updated this cycle
O_IBUF_RD_AVAIL  out  1  read bank is FULL
I_IBUF_RD_DONE  in  1  release read bank
O_IBUF_FULL_CNT  out  2  number of FULL banks (0..2)
O_IBUF_ERR  out  1  sticky: out-of-range write lane seen

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - both banks EMPTY; wr_bank=0, rd_bank=0; byte counter=0.
  - RDATA=0, RDATA_VALID=0, ERR=0, FULL_CNT=0.
  - WREADY=1, RD_AVAIL=0.
  - Memory arrays are NOT reset; unwritten bytes read as don't-care.
- Per-bank FSM, states EMPTY, FILL, FULL:
  - EMPTY->FILL on first accepted beat.
  - FILL->FULL when count reaches FILL_LEN.
  - FULL->EMPTY on RD_DONE while that bank is rd_bank.
- WREADY = (state[wr_bank] != FULL). Beat accepted when WVALID & WREADY.
- Accepted beat handling:
  - each lane with WSTRB=1 and WADDR<DEPTH writes mem[wr_bank][addr]; counter += number of such lanes.
  - a strobed lane with WADDR>=DEPTH is dropped and sets ERR (sticky until reset).
  - duplicate lane addresses in one beat: highest lane wins.
- FILL_LEN is sampled on EMPTY->FILL and held for that bank.
- Completing beat (counter+added >= FILL_LEN):
  - all its lanes are written to the current bank.
  - next cycle: bank FULL, counter=0, wr_bank toggles.
  - overshoot bytes are discarded from the count.
- Reads:
  - RD_AVAIL = (state[rd_bank]==FULL).
  - on RVALID & RD_AVAIL, each channel c registers next cycle: PAD_VAL if RPAD[c] or RADDR[c]>=DEPTH, else mem[rd_bank][RADDR[c]].
  - RDATA_VALID pulses 1 for that cycle. Latency is exactly 1.
  - RVALID without RD_AVAIL is ignored; RDATA holds, RDATA_VALID=0.
- RD_DONE:
  - with RD_AVAIL: bank->EMPTY and rd_bank toggles next cycle.
  - without RD_AVAIL: ignored.
  - RVALID+RD_DONE in the same cycle: the read is served from the old bank, then released.
- Simultaneous bank completion and RD_DONE on the other bank: both take effect; FULL_CNT is unchanged.
- Fill completing into a bank while the other is FULL: WREADY=0 next cycle until RD_DONE.
- FULL_CNT = count of banks in FULL, registered with the state.

Decomposition:
- Package ibuf_pkg holds:
  - bank state encoding (EMPTY=2'd0, FILL=2'd1, FULL=2'd2).
  - BPW derivation constant.
  - default PAD_VAL.
  - popcount function for the strobe.
- Sub-module ibuf_bank: one DEPTH x 8 array with BPW write lanes and NUM_CH registered read ports. It is instantiated twice; the top holds the FSMs, counter, pointers and muxing.

Test Plan:
1. Async reset asserted mid-cycle -> outputs immediately: RDATA=0, RDATA_VALID=0, ERR=0, FULL_CNT=0, WREADY=1, RD_AVAIL=0.
2. FILL_LEN=0, 48 full-strobe beats, lane addrs 4k..4k+3, data 0x03020100+0x04040404*k -> cycle after beat 48: RD_AVAIL=1, FULL_CNT=1, WREADY=1. RADDR=(5,6,7) -> next cycle RDATA = (0x05,0x06,0x07) with RDATA_VALID=1.
3. Fill both banks without RD_DONE -> after beat 96 WREADY=0 and FULL_CNT=2; further WVALID is not accepted. RD_DONE -> next cycle WREADY=1, FULL_CNT=1, rd_bank=1, and reads return bank-1 data.
4. RPAD=3'b010, RADDR=(0,1,200) -> (mem[0], 0x00, 0x00). ERR stays 0.
5. FILL_LEN=6, three beats with WSTRB=4'b0011 -> FULL only after the third beat. A beat with WSTRB=4'b0001 and lane-0 addr 195 -> ERR=1, counter unchanged, ERR held after the bank swaps.
6. RVALID and RD_DONE in the same cycle on FULL bank 0 -> RDATA carries bank-0 bytes, and next cycle RD_AVAIL reflects bank 1. Repeat with the other bank completing in that same cycle -> FULL_CNT stays 1.

Source files
------------

// File: rtl/ibuf_pkg.sv
// Shared definitions for the ping-pong input pixel buffer.
//   bank_state_e      : per-bank fill state encoding
//   IBUF_MAX_LANES    : widest write beat (in byte lanes) the strobe popcount handles
//   IBUF_PAD_VAL_DEF  : default byte returned for padded / out-of-range reads
//   ibuf_bpw()        : byte lanes per write beat for a given beat width
//   ibuf_popcount()   : number of set bits in a (zero-extended) lane mask
package ibuf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_e;

  localparam int IBUF_MAX_LANES = 64;
  localparam logic [7:0] IBUF_PAD_VAL_DEF = 8'h00;

  function automatic int ibuf_bpw(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [6:0] ibuf_popcount(input logic [IBUF_MAX_LANES-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < IBUF_MAX_LANES; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ibuf_bank.sv
// One DEPTH x 8 byte bank of the ping-pong buffer.
//   clk, rst_n : clock, async active-low reset (read registers only)
//   wr_en      : per-lane write enable; lanes are pre-qualified by the top
//   wr_addr    : per-lane byte address, ADDR_W bits per lane
//   wr_data    : per-lane write byte
//   rd_en      : capture all read channels this cycle
//   rd_addr    : per-channel byte address, ADDR_W bits per channel
//   rd_data    : registered per-channel read bytes; hold when rd_en is low
module ibuf_bank #(
  parameter int DEPTH  = 192,
  parameter int ADDR_W = 8,
  parameter int BPW    = 4,
  parameter int NUM_CH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BPW-1:0]           wr_en,
  input  logic [BPW*ADDR_W-1:0]    wr_addr,
  input  logic [BPW*8-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
  output logic [NUM_CH*8-1:0]      rd_data
);

  // Storage is intentionally left unreset.
  logic [7:0] mem [DEPTH];

  logic [NUM_CH*8-1:0] rd_data_q;
  logic [NUM_CH*8-1:0] rd_data_d;

  // Lanes are visited in ascending order, so on duplicate addresses within
  // one beat the last (highest) lane's assignment is the one that lands.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BPW; k++) begin
      if (wr_en[k]) begin
        mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*8 +: 8];
      end
    end
  end

  // Out-of-range channels are padded by the top, so they just keep the old byte.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (32'(rd_addr[c*ADDR_W +: ADDR_W]) < 32'(DEPTH)) begin
          rd_data_d[c*8 +: 8] = mem[rd_addr[c*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/input_pixel_pingpong_buf.sv
// Double-banked input pixel buffer. The pixel core fills one bank with
// BPW byte lanes per beat while the rotate datapath reads NUM_CH byte
// channels from the other bank; banks swap on fill completion / RD_DONE.
//   I_IBUF_HCLK / I_IBUF_HRESET_N : clock, async active-low reset
//   I_IBUF_WVALID / O_IBUF_WREADY : write beat handshake
//   I_IBUF_WDATA/WSTRB/WADDR      : per-lane byte, enable and address
//   I_IBUF_FILL_LEN               : bytes completing a bank (0 = DEPTH)
//   I_IBUF_RVALID/RADDR/RPAD      : read request, per-channel addr / pad force
//   O_IBUF_RDATA / RDATA_VALID    : read bytes, one cycle after request
//   O_IBUF_RD_AVAIL / I_IBUF_RD_DONE : read bank full / release read bank
//   O_IBUF_FULL_CNT               : number of FULL banks
//   O_IBUF_ERR                    : sticky out-of-range write lane flag
//
// Bank state | meaning
// -----------+---------------------------------------------------------
// EMPTY      | free; next accepted beat starts a fill and samples FILL_LEN
// FILL       | being written; byte count below its fill length
// FULL       | holds a complete frame slice; readable, not writable
module input_pixel_pingpong_buf
  import ibuf_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         DEPTH   = 192,
  parameter int         ADDR_W  = 8,
  parameter int         NUM_CH  = 3,
  parameter logic [7:0] PAD_VAL = IBUF_PAD_VAL_DEF,
  localparam int        BPW     = ibuf_bpw(DATA_W)
) (
  input  logic                     I_IBUF_HCLK,
  input  logic                     I_IBUF_HRESET_N,
  input  logic                     I_IBUF_WVALID,
  output logic                     O_IBUF_WREADY,
  input  logic [DATA_W-1:0]        I_IBUF_WDATA,
  input  logic [BPW-1:0]           I_IBUF_WSTRB,
  input  logic [BPW*ADDR_W-1:0]    I_IBUF_WADDR,
  input  logic [ADDR_W:0]          I_IBUF_FILL_LEN,
  input  logic                     I_IBUF_RVALID,
  input  logic [NUM_CH*ADDR_W-1:0] I_IBUF_RADDR,
  input  logic [NUM_CH-1:0]        I_IBUF_RPAD,
  output logic [NUM_CH*8-1:0]      O_IBUF_RDATA,
  output logic                     O_IBUF_RDATA_VALID,
  output logic                     O_IBUF_RD_AVAIL,
  input  logic                     I_IBUF_RD_DONE,
  output logic [1:0]               O_IBUF_FULL_CNT,
  output logic                     O_IBUF_ERR
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;

  bank_state_e          bank_st_q [2];
  bank_state_e          bank_st_d [2];
  logic [CNT_W-1:0]     len_q [2];
  logic [CNT_W-1:0]     len_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [1:0]           full_cnt_q, full_cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rsel_q, rsel_d;
  logic [NUM_CH-1:0]    rpad_q, rpad_d;

  logic                 wr_ready, rd_avail, wr_acc, rd_fire, rd_release;
  logic [BPW-1:0]       lane_ok, lane_we;
  logic                 lane_bad;
  logic [IBUF_MAX_LANES-1:0] we_ext;
  logic [6:0]           added;
  logic [SUM_W-1:0]     sum;
  logic [CNT_W-1:0]     fill_len_eff, len_now;
  logic                 fill_done;

  logic [BPW-1:0]       bank_we [2];
  logic [1:0]           bank_re;
  logic [NUM_CH*8-1:0]  bank_rdata [2];

  assign wr_ready   = (bank_st_q[wr_bank_q] != BANK_FULL);
  assign rd_avail   = (bank_st_q[rd_bank_q] == BANK_FULL);
  assign wr_acc     = I_IBUF_WVALID & wr_ready;
  assign rd_fire    = I_IBUF_RVALID & rd_avail;
  assign rd_release = I_IBUF_RD_DONE & rd_avail;

  always_comb begin
    lane_ok = '0;
    for (int k = 0; k < BPW; k++) begin
      lane_ok[k] = (32'(I_IBUF_WADDR[k*ADDR_W +: ADDR_W]) < 32'(DEPTH));
    end
    lane_we  = {BPW{wr_acc}} & I_IBUF_WSTRB & lane_ok;
    lane_bad = wr_acc & (|(I_IBUF_WSTRB & ~lane_ok));
    we_ext   = '0;
    we_ext[BPW-1:0] = lane_we;
    added    = ibuf_popcount(we_ext);
  end

  // A bank leaving EMPTY uses the live FILL_LEN; afterwards its held copy.
  always_comb begin
    fill_len_eff = (I_IBUF_FILL_LEN == '0) ? CNT_W'(DEPTH) : I_IBUF_FILL_LEN;
    len_now      = (bank_st_q[wr_bank_q] == BANK_EMPTY) ? fill_len_eff : len_q[wr_bank_q];
    sum          = SUM_W'(cnt_q) + SUM_W'(added);
    fill_done    = (sum >= SUM_W'(len_now));
  end

  // The write bank is never FULL while accepting and the read bank is always
  // FULL while releasing, so both updates below never touch the same bank.
  always_comb begin
    bank_st_d = bank_st_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_acc) begin
      if (bank_st_q[wr_bank_q] == BANK_EMPTY) begin
        len_d[wr_bank_q] = fill_len_eff;
      end
      if (fill_done) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        cnt_d                = '0;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILL;
        cnt_d                = sum[CNT_W-1:0];
      end
    end
    if (rd_release) begin
      bank_st_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d            = ~rd_bank_q;
    end
    full_cnt_d = 2'(bank_st_d[0] == BANK_FULL) + 2'(bank_st_d[1] == BANK_FULL);
    err_d      = err_q | lane_bad;
  end

  // Pad decisions and the source bank are captured alongside the bank's
  // read registers so the output mux only ever looks at flops.
  always_comb begin
    rvalid_d = rd_fire;
    rsel_d   = rsel_q;
    rpad_d   = rpad_q;
    if (rd_fire) begin
      rsel_d = rd_bank_q;
      for (int c = 0; c < NUM_CH; c++) begin
        rpad_d[c] = I_IBUF_RPAD[c] |
                    (32'(I_IBUF_RADDR[c*ADDR_W +: ADDR_W]) >= 32'(DEPTH));
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b] = (wr_bank_q == 1'(b)) ? lane_we : '0;
      bank_re[b] = rd_fire & (rd_bank_q == 1'(b));
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ibuf_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BPW    (BPW),
      .NUM_CH (NUM_CH)
    ) u_bank (
      .clk     (I_IBUF_HCLK),
      .rst_n   (I_IBUF_HRESET_N),
      .wr_en   (bank_we[b]),
      .wr_addr (I_IBUF_WADDR),
      .wr_data (I_IBUF_WDATA),
      .rd_en   (bank_re[b]),
      .rd_addr (I_IBUF_RADDR),
      .rd_data (bank_rdata[b])
    );
  end

  always_ff @(posedge I_IBUF_HCLK or negedge I_IBUF_HRESET_N) begin
    if (!I_IBUF_HRESET_N) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b] <= BANK_EMPTY;
        len_q[b]     <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      full_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rsel_q     <= 1'b0;
      rpad_q     <= '0;
    end else begin
      bank_st_q  <= bank_st_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      full_cnt_q <= full_cnt_d;
      rvalid_q   <= rvalid_d;
      rsel_q     <= rsel_d;
      rpad_q     <= rpad_d;
    end
  end

  always_comb begin
    O_IBUF_RDATA = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      O_IBUF_RDATA[c*8 +: 8] = rpad_q[c] ? PAD_VAL : bank_rdata[rsel_q][c*8 +: 8];
    end
  end

  assign O_IBUF_WREADY      = wr_ready;
  assign O_IBUF_RD_AVAIL    = rd_avail;
  assign O_IBUF_RDATA_VALID = rvalid_q;
  assign O_IBUF_FULL_CNT    = full_cnt_q;
  assign O_IBUF_ERR         = err_q;

endmodule

// File: tb/tb_input_pixel_pingpong_buf.sv
// Bench for input_pixel_pingpong_buf: directed stimulus, a behavioural
// model of the two banks checked every cycle, plus literal expectations.
module tb_input_pixel_pingpong_buf;

  localparam int DEPTH  = 192;
  localparam int NUM_CH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] waddr;
  logic [8:0]  fill_len;
  logic        rvalid;
  logic [23:0] raddr;
  logic [2:0]  rpad;
  logic [23:0] rdata;
  logic        rdata_valid;
  logic        rd_avail;
  logic        rd_done;
  logic [1:0]  full_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  input_pixel_pingpong_buf dut (
    .I_IBUF_HCLK        (clk),
    .I_IBUF_HRESET_N    (rst_n),
    .I_IBUF_WVALID      (wvalid),
    .O_IBUF_WREADY      (wready),
    .I_IBUF_WDATA       (wdata),
    .I_IBUF_WSTRB       (wstrb),
    .I_IBUF_WADDR       (waddr),
    .I_IBUF_FILL_LEN    (fill_len),
    .I_IBUF_RVALID      (rvalid),
    .I_IBUF_RADDR       (raddr),
    .I_IBUF_RPAD        (rpad),
    .O_IBUF_RDATA       (rdata),
    .O_IBUF_RDATA_VALID (rdata_valid),
    .O_IBUF_RD_AVAIL    (rd_avail),
    .I_IBUF_RD_DONE     (rd_done),
    .O_IBUF_FULL_CNT    (full_cnt),
    .O_IBUF_ERR         (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bank status: 0 free, 1 partially written, 2 complete.
  int         m_st [2];
  int         m_len [2];
  int         m_cnt;
  bit         m_wr, m_rd, m_err, m_rv;
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  logic [7:0] m_rdat [NUM_CH];
  bit         m_rk [NUM_CH];
  bit         m_acc, m_ok;
  int         m_n, m_need, m_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st[0] = 0; m_st[1] = 0; m_len[0] = 0; m_len[1] = 0;
      m_cnt = 0; m_wr = 0; m_rd = 0; m_err = 0; m_rv = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_rdat[c] = 8'h00; m_rk[c] = 1; end
    end else begin
      m_acc = wvalid && (m_st[m_wr] != 2);
      m_ok  = (m_st[m_rd] == 2);
      m_rv  = rvalid && m_ok;
      if (m_rv) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_a = int'(raddr[8*c +: 8]);
          if (rpad[c] || m_a >= DEPTH) begin
            m_rdat[c] = 8'h00; m_rk[c] = 1;
          end else begin
            m_rdat[c] = m_mem[m_rd][m_a]; m_rk[c] = m_known[m_rd][m_a];
          end
        end
      end
      if (m_acc) begin
        m_n = 0;
        for (int k = 0; k < 4; k++) begin
          if (wstrb[k]) begin
            m_a = int'(waddr[8*k +: 8]);
            if (m_a < DEPTH) begin
              m_mem[m_wr][m_a] = wdata[8*k +: 8];
              m_known[m_wr][m_a] = 1;
              m_n++;
            end else begin
              m_err = 1;
            end
          end
        end
        if (m_st[m_wr] == 0) m_len[m_wr] = (fill_len == 0) ? DEPTH : int'(fill_len);
        m_need = m_len[m_wr];
        if (m_cnt + m_n >= m_need) begin
          m_st[m_wr] = 2; m_cnt = 0; m_wr = !m_wr;
        end else begin
          m_st[m_wr] = 1; m_cnt = m_cnt + m_n;
        end
      end
      if (rd_done && m_ok) begin
        m_st[m_rd] = 0; m_rd = !m_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("wready", 32'(wready), 32'(m_st[m_wr] != 2));
      chk("rd_avail", 32'(rd_avail), 32'(m_st[m_rd] == 2));
      chk("full_cnt", 32'(full_cnt), 32'((m_st[0] == 2) + (m_st[1] == 2)));
      chk("err", 32'(err), 32'(m_err));
      chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_rk[c]) chk("rdata_ch", 32'(rdata[8*c +: 8]), 32'(m_rdat[c]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic [31:0] a);
    wvalid = 1'b1; wdata = d; wstrb = s; waddr = a;
    cyc();
    wvalid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [23:0] a, input logic [2:0] pad, input logic done);
    rvalid = 1'b1; raddr = a; rpad = pad; rd_done = done;
    cyc();
    rvalid = 1'b0; rpad = 3'b000; rd_done = 1'b0;
  endtask

  // 48 full-strobe beats, lane byte = base + address, addresses 4k..4k+3.
  task automatic fill(input int base);
    for (int k = 0; k < 48; k++) begin
      wvalid = 1'b1; wstrb = 4'hF;
      for (int j = 0; j < 4; j++) begin
        wdata[8*j +: 8] = 8'(base + 4*k + j);
        waddr[8*j +: 8] = 8'(4*k + j);
      end
      cyc();
    end
    wvalid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_full_cnt", 32'(full_cnt), 32'h0);
    chk("rst_wready", 32'(wready), 32'h1);
    chk("rst_rd_avail", 32'(rd_avail), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; wvalid = 0; wdata = 0; wstrb = 0; waddr = 0; fill_len = 0;
    rvalid = 0; raddr = 0; rpad = 0; rd_done = 0;
    #3 rst_n = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1;
    cyc();

    // Full-depth fill of bank 0: mem[a] = a.
    fill(0);
    chk("t2_rd_avail", 32'(rd_avail), 32'h1);
    chk("t2_full_cnt", 32'(full_cnt), 32'h1);
    chk("t2_wready", 32'(wready), 32'h1);
    rd({8'd7, 8'd6, 8'd5}, 3'b000, 1'b0);
    chk("t2_rdata", 32'(rdata), 32'h070605);
    chk("t2_rdata_valid", 32'(rdata_valid), 32'h1);
    cyc();
    chk("t2_rdata_hold", 32'(rdata), 32'h070605);
    chk("t2_valid_drop", 32'(rdata_valid), 32'h0);

    // Bank 1 fill, both full, rejected beats, then release bank 0.
    fill(8'h80);
    chk("t3_wready", 32'(wready), 32'h0);
    chk("t3_full_cnt", 32'(full_cnt), 32'h2);
    wvalid = 1'b1; wstrb = 4'hF; wdata = 32'h99999999; waddr = {8'd8, 8'd7, 8'd6, 8'd5};
    cyc(); cyc();
    wvalid = 1'b0; wstrb = 4'h0;
    chk("t3_blocked_cnt", 32'(full_cnt), 32'h2);
    rd_done = 1'b1; cyc(); rd_done = 1'b0;
    chk("t3_rel_wready", 32'(wready), 32'h1);
    chk("t3_rel_full_cnt", 32'(full_cnt), 32'h1);
    chk("t3_rel_rd_avail", 32'(rd_avail), 32'h1);
    rd({8'd2, 8'd1, 8'd0}, 3'b000, 1'b0);
    chk("t3_bank1_data", 32'(rdata), 32'h828180);

    // Pad force and out-of-range read address.
    rd({8'd200, 8'd1, 8'd0}, 3'b010, 1'b0);
    chk("t4_pad", 32'(rdata), 32'h000080);
    chk("t4_err", 32'(err), 32'h0);

    // Short fill into bank 0 with an out-of-range lane in the middle;
    // FILL_LEN changes mid-fill and must not affect this bank.
    fill_len = 9'd6;
    beat(32'h0000BBAA, 4'b0011, {8'd0, 8'd0, 8'd11, 8'd10});
    fill_len = 9'd100;
    chk("t5_b1_full_cnt", 32'(full_cnt), 32'h1);
    beat(32'h0000DDCC, 4'b0011, {8'd0, 8'd0, 8'd13, 8'd12});
    chk("t5_b2_full_cnt", 32'(full_cnt), 32'h1);
    beat(32'h000000EE, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd195});
    chk("t5_err_set", 32'(err), 32'h1);
    chk("t5_err_full_cnt", 32'(full_cnt), 32'h1);
    beat(32'h0000F0E0, 4'b0011, {8'd0, 8'd0, 8'd15, 8'd14});
    chk("t5_b3_full_cnt", 32'(full_cnt), 32'h2);
    chk("t5_b3_wready", 32'(wready), 32'h0);

    // Release bank 1, then read-and-release bank 0 in one cycle.
    rd_done = 1'b1; cyc(); rd_done = 1'b0;
    chk("t6_err_held", 32'(err), 32'h1);
    chk("t6_full_cnt", 32'(full_cnt), 32'h1);
    rd({8'd14, 8'd5, 8'd10}, 3'b000, 1'b1);
    chk("t6_rdata", 32'(rdata), 32'hE005AA);
    chk("t6_rdata_valid", 32'(rdata_valid), 32'h1);
    chk("t6_rd_avail", 32'(rd_avail), 32'h0);
    chk("t6_full_cnt0", 32'(full_cnt), 32'h0);
    rd({8'd0, 8'd0, 8'd0}, 3'b000, 1'b0);
    chk("t6_ignored_valid", 32'(rdata_valid), 32'h0);
    chk("t6_ignored_hold", 32'(rdata), 32'hE005AA);

    // Bank 1 fill with overshoot, bank 0 near-complete (duplicate lane addr),
    // then completion of bank 0 together with read+release of bank 1.
    fill_len = 9'd6;
    beat(32'hD7D6D5D4, 4'hF, {8'd23, 8'd22, 8'd21, 8'd20});
    beat(32'hDBDAD9D8, 4'hF, {8'd27, 8'd26, 8'd25, 8'd24});
    chk("t6b_full_cnt", 32'(full_cnt), 32'h1);
    beat(32'h44332211, 4'hF, {8'd31, 8'd32, 8'd31, 8'd30});
    wvalid = 1'b1; wdata = 32'h00006655; wstrb = 4'b0011; waddr = {8'd0, 8'd0, 8'd35, 8'd34};
    rd({8'd25, 8'd23, 8'd20}, 3'b000, 1'b1);
    wvalid = 1'b0; wstrb = 4'h0;
    chk("t6b_rdata", 32'(rdata), 32'hD9D7D4);
    chk("t6b_full_cnt_same", 32'(full_cnt), 32'h1);
    chk("t6b_rd_avail", 32'(rd_avail), 32'h1);
    chk("t6b_wready", 32'(wready), 32'h1);
    rd({8'd35, 8'd31, 8'd30}, 3'b000, 1'b0);
    chk("t6b_bank0_data", 32'(rdata), 32'h664411);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outs();
    chk_en = 0;
    #10 rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
